// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the burst I2C master
package i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_START    = 4'd1;
    localparam state_t ST_ADDR     = 4'd2;
    localparam state_t ST_ADDR_ACK = 4'd3;
    localparam state_t ST_WR_BYTE  = 4'd4;
    localparam state_t ST_WR_ACK   = 4'd5;
    localparam state_t ST_RD_BYTE  = 4'd6;
    localparam state_t ST_RD_ACK   = 4'd7;
    localparam state_t ST_STOP     = 4'd8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - quarter-period bit timer with sample/bit-end strobes and hold
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       run_i,
    input  logic       hold_i,
    output logic [1:0] phase_o,
    output logic       sample_o,
    output logic       bit_end_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          q_last;

    assign q_last = (cnt_q == CW'(CLK_DIV - 1)) && !hold_i;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (q_last) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (!hold_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o   = phase_q;
    assign sample_o  = run_i && (phase_q == Q2) && q_last;
    assign bit_end_o = run_i && (phase_q == Q3) && q_last;

endmodule

// File: rtl/i2c_master_burst.sv
// rtl/i2c_master_burst.sv - burst I2C master, open-drain pads
// Optional slave clock stretching: define I2C_CLK_STRETCH_EN.
module i2c_master_burst
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_rd_wr,
    input  logic [6:0]       i_slave_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_tx_data,
    output logic             o_tx_req,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_nack,
    inout  wire              io_sda,
    inout  wire              io_scl
);

    state_t           state_q, state_d;
    logic [2:0]       bit_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       shift_q, rx_data_q;
    logic             rw_q, ack_q, nack_q, rx_valid_q;
    logic             sda_low_q, sda_low_d, scl_low_q, scl_low_d;
    logic [1:0]       phase;
    logic             sample_stb, bit_end, hold;

`ifdef I2C_CLK_STRETCH_EN
    // SCL released by us but still low on the wire: a slave is stretching
    assign hold = (phase == Q2) && !scl_low_q && !io_scl
                  && (state_q != ST_IDLE) && (state_q != ST_START);
`else
    assign hold = 1'b0;
`endif

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_i     (clk),
        .resetn_i  (rst),
        .run_i     (state_q != ST_IDLE),
        .hold_i    (hold),
        .phase_o   (phase),
        .sample_o  (sample_stb),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_start) state_d = ST_START;
            ST_START:    if (bit_end) state_d = ST_ADDR;
            ST_ADDR:     if (bit_end && bit_q == 3'd7) state_d = ST_ADDR_ACK;
            ST_ADDR_ACK: if (bit_end) begin
                if (ack_q == NACK || cnt_q == '0) state_d = ST_STOP;
                else if (rw_q)                    state_d = ST_RD_BYTE;
                else                              state_d = ST_WR_BYTE;
            end
            ST_WR_BYTE:  if (bit_end && bit_q == 3'd7) state_d = ST_WR_ACK;
            ST_WR_ACK:   if (bit_end) state_d = (ack_q == NACK || cnt_q == '0) ? ST_STOP : ST_WR_BYTE;
            ST_RD_BYTE:  if (bit_end && bit_q == 3'd7) state_d = ST_RD_ACK;
            ST_RD_ACK:   if (bit_end) state_d = (cnt_q == '0) ? ST_STOP : ST_RD_BYTE;
            ST_STOP:     if (bit_end) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sda_low_d = 1'b0;
        scl_low_d = 1'b0;
        o_tx_req  = 1'b0;
        o_done    = 1'b0;
        o_busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_START: sda_low_d = (phase >= Q2);
            ST_ADDR, ST_WR_BYTE: begin
                scl_low_d = (phase < Q2);
                sda_low_d = ~shift_q[7];
            end
            ST_ADDR_ACK, ST_WR_ACK: begin
                scl_low_d = (phase < Q2);
                o_tx_req  = bit_end && !rw_q && (ack_q == ACK) && (cnt_q != '0);
            end
            ST_RD_BYTE: scl_low_d = (phase < Q2);
            // ACK every read byte except the last, which is left released as NACK
            ST_RD_ACK: begin
                scl_low_d = (phase < Q2);
                sda_low_d = (cnt_q != '0);
            end
            ST_STOP: begin
                scl_low_d = (phase < Q2);
                sda_low_d = 1'b1;
                o_done    = bit_end;
            end
            default: ;
        endcase
        o_nack = nack_q && ((state_q == ST_IDLE) || o_done);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            ack_q      <= ACK;
            nack_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_low_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            sda_low_q  <= sda_low_d;
            scl_low_q  <= scl_low_d;
            if (state_q == ST_IDLE && i_start) begin
                rw_q    <= i_rd_wr;
                shift_q <= {i_slave_addr, i_rd_wr};
                cnt_q   <= (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
                bit_q   <= '0;
                nack_q  <= 1'b0;
            end
            if (sample_stb) begin
                if (state_q == ST_ADDR_ACK || state_q == ST_WR_ACK) ack_q <= io_sda;
                if (state_q == ST_RD_BYTE) begin
                    shift_q <= {shift_q[6:0], io_sda};
                    if (bit_q == 3'd7) begin
                        rx_data_q  <= {shift_q[6:0], io_sda};
                        rx_valid_q <= 1'b1;
                    end
                end
            end
            if (bit_end) begin
                if (state_q == ST_ADDR || state_q == ST_WR_BYTE) begin
                    shift_q <= {shift_q[6:0], 1'b0};
                    bit_q   <= bit_q + 3'd1;
                end
                if (state_q == ST_RD_BYTE) bit_q <= bit_q + 3'd1;
                if ((state_q == ST_WR_BYTE || state_q == ST_RD_BYTE) && bit_q == 3'd7)
                    cnt_q <= cnt_q - LEN_W'(1);
                if ((state_q == ST_ADDR_ACK || state_q == ST_WR_ACK) && ack_q == NACK)
                    nack_q <= 1'b1;
            end
            if (o_tx_req) shift_q <= i_tx_data;
        end
    end

    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign io_sda     = sda_low_q ? 1'b0 : 1'bz;
    assign io_scl     = scl_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_burst.sv
// tb/tb_i2c_master_burst.sv - directed bench with slave BFM and transaction-level model
module tb_i2c_master_burst;

    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_start = 1'b0;
    logic             i_rd_wr = 1'b0;
    logic [6:0]       i_slave_addr = '0;
    logic [LEN_W-1:0] i_len = '0;
    logic [7:0]       i_tx_data = '0;
    wire              o_tx_req, o_rx_valid, o_busy, o_done, o_nack;
    wire  [7:0]       o_rx_data;
    wire              sda, scl;
    logic             bfm_sda_low = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = bfm_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_rd_wr      (i_rd_wr),
        .i_slave_addr (i_slave_addr),
        .i_len        (i_len),
        .i_tx_data    (i_tx_data),
        .o_tx_req     (o_tx_req),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_nack       (o_nack),
        .io_sda       (sda),
        .io_scl       (scl)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] wr_data[$];
    logic [7:0] rd_data[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_got[$];
    logic [7:0] bus_q[$];
    logic       mack_q[$];
    int  rx_i, tx_idx, tx_cnt, done_cnt, starts, stops;
    bit  tx_pending = 0, exp_nack = 0, done_prev = 0;
    bit  addr_nack = 0;
    int  nack_at = -1;

    // slave BFM: samples the bus on every falling clk edge
    bit         active = 0, slave_tx = 0;
    int         bit_i, byte_i, rd_i, cyc = 0, last_rise = -1;
    logic [7:0] cur, txb;
    logic       s, c, prev_sda = 1'b1, prev_scl = 1'b1;

    always @(negedge clk) begin
        cyc++;
        s = sda;
        c = scl;
        if (!rst) begin
            active = 0;
            bfm_sda_low = 1'b0;
        end else if (prev_scl && c && prev_sda && !s) begin
            starts++;
            active = 1; slave_tx = 0; bit_i = 0; byte_i = 0; last_rise = -1;
            bfm_sda_low = 1'b0;
        end else if (prev_scl && c && !prev_sda && s) begin
            stops++;
            active = 0;
            bfm_sda_low = 1'b0;
        end else if (active) begin
            if (!prev_scl && c) begin
                if (last_rise >= 0) chk("scl_period", cyc - last_rise, 4 * CLK_DIV);
                last_rise = cyc;
                if (bit_i < 8) begin
                    if (!slave_tx) cur = {cur[6:0], s};
                end else if (slave_tx) begin
                    mack_q.push_back(s);
                end
                bit_i++;
            end
            if (prev_scl && !c) begin
                if (bit_i == 8) begin
                    if (!slave_tx) begin
                        bus_q.push_back(cur);
                        bfm_sda_low = (byte_i == 0) ? !addr_nack : ((byte_i - 1) != nack_at);
                    end else begin
                        bfm_sda_low = 1'b0;
                    end
                end else if (bit_i == 9) begin
                    bit_i = 0;
                    bfm_sda_low = 1'b0;
                    if (byte_i == 0 && bus_q.size() > 0 && bus_q[$][0] && !addr_nack) begin
                        slave_tx = 1;
                        txb = rd_data[0];
                        rd_i = 1;
                        bfm_sda_low = !txb[7];
                    end else if (slave_tx) begin
                        if (mack_q.size() > 0 && mack_q[$] == 1'b0 && rd_i < rd_data.size()) begin
                            txb = rd_data[rd_i];
                            rd_i++;
                            bfm_sda_low = !txb[7];
                        end else begin
                            active = 0;
                        end
                    end
                    byte_i++;
                end else if (slave_tx && bit_i >= 1 && bit_i <= 7) begin
                    bfm_sda_low = !txb[7 - bit_i];
                end
            end
        end
        prev_sda = s;
        prev_scl = c;
    end

    // compare process: checks host-side outputs on every cycle they carry meaning
    always @(negedge clk) begin
        if (rst) begin
            if (o_rx_valid) begin
                rx_got.push_back(o_rx_data);
                if (rx_i < exp_rx.size()) chk("rx_data", o_rx_data, exp_rx[rx_i]);
                else                      chk("rx_extra", rx_i + 1, exp_rx.size());
                rx_i++;
            end
            if (o_tx_req) begin
                tx_cnt++;
                tx_pending = 1;
            end
            if (o_done) begin
                done_cnt++;
                chk("nack_at_done", o_nack, exp_nack);
                chk("busy_at_done", o_busy, 1);
            end
            if (done_prev) chk("busy_after_done", o_busy, 0);
            done_prev = o_done;
        end else begin
            done_prev = 0;
        end
    end

    // present the next write byte once the current one has been consumed
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_pending) begin
                tx_pending = 0;
                tx_idx++;
                i_tx_data = (tx_idx < wr_data.size()) ? wr_data[tx_idx] : 8'h00;
            end
        end
    end

    task automatic clear_model();
        bus_q.delete(); mack_q.delete(); exp_rx.delete(); rx_got.delete();
        starts = 0; stops = 0; rx_i = 0; tx_cnt = 0; done_cnt = 0; tx_idx = 0;
        i_tx_data = (wr_data.size() > 0) ? wr_data[0] : 8'h00;
    endtask

    task automatic run_cmd(input string nm, input bit rw, input logic [6:0] addr, input int len,
                           input bit a_nack, input int n_at, input bit poke);
        int len_eff, n_wr;
        len_eff = (len > MAX_LEN) ? MAX_LEN : len;
        addr_nack = a_nack;
        nack_at = n_at;
        clear_model();
        if (a_nack || rw) n_wr = 0;
        else if (n_at >= 0 && n_at < len_eff) n_wr = n_at + 1;
        else n_wr = len_eff;
        exp_nack = a_nack || (!rw && n_at >= 0 && n_at < len_eff);
        if (rw && !a_nack) for (int i = 0; i < len_eff; i++) exp_rx.push_back(rd_data[i]);
        @(negedge clk);
        i_rd_wr = rw; i_slave_addr = addr; i_len = LEN_W'(len); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
            if (poke && k == 100) begin
                i_slave_addr = 7'h11; i_rd_wr = 1'b1; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk({nm, "_done"}, done_cnt, 1);
        chk({nm, "_tx_req"}, tx_cnt, n_wr);
        chk({nm, "_bus_len"}, bus_q.size(), 1 + n_wr);
        if (bus_q.size() > 0) chk({nm, "_addr_byte"}, bus_q[0], {addr, rw});
        for (int i = 0; i < n_wr && i + 1 < bus_q.size(); i++)
            chk({nm, "_wr_byte"}, bus_q[i + 1], wr_data[i]);
        if (rw && !a_nack) begin
            chk({nm, "_rx_cnt"}, rx_i, len_eff);
            chk({nm, "_mack_cnt"}, mack_q.size(), len_eff);
            for (int i = 0; i < len_eff && i < mack_q.size(); i++)
                chk({nm, "_master_ack"}, mack_q[i], (i == len_eff - 1) ? 1 : 0);
        end
        chk({nm, "_starts"}, starts, 1);
        chk({nm, "_stops"}, stops, 1);
        chk({nm, "_nack_held"}, o_nack, exp_nack);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_sda"}, sda, 1);
        chk({nm, "_scl"}, scl, 1);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_done"}, o_done, 0);
        chk({nm, "_tx_req"}, o_tx_req, 0);
        chk({nm, "_rx_valid"}, o_rx_valid, 0);
        chk({nm, "_rx_data"}, o_rx_data, 0);
        chk({nm, "_nack"}, o_nack, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        wr_data = '{8'hA5, 8'h3C, 8'hFF};
        run_cmd("wr3", 1'b0, 7'h50, 3, 1'b0, -1, 1'b0);
        if (bus_q.size() > 0) chk("lit_wr_addr", bus_q[0], 8'hA0);
        chk("lit_wr_txreq", tx_cnt, 3);

        rd_data = '{8'h12, 8'h34};
        run_cmd("rd2", 1'b1, 7'h51, 2, 1'b0, -1, 1'b0);
        if (rx_got.size() == 2) begin
            chk("lit_rx0", rx_got[0], 8'h12);
            chk("lit_rx1", rx_got[1], 8'h34);
        end else chk("lit_rx_count", rx_got.size(), 2);

        wr_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_cmd("addr_nack", 1'b0, 7'h22, 4, 1'b1, -1, 1'b0);
        if (bus_q.size() > 0) chk("lit_nack_addr", bus_q[0], 8'h44);
        chk("lit_nack_flag", o_nack, 1);

        run_cmd("data_nack", 1'b0, 7'h2A, 4, 1'b0, 1, 1'b0);
        chk("lit_data_nack_txreq", tx_cnt, 2);

        run_cmd("probe", 1'b0, 7'h3C, 0, 1'b0, -1, 1'b0);

        wr_data.delete();
        for (int i = 0; i < MAX_LEN; i++) wr_data.push_back(8'(8'h10 + i * 7));
        run_cmd("clamp", 1'b0, 7'h0F, 20, 1'b0, -1, 1'b0);
        chk("lit_clamp_txreq", tx_cnt, 16);

        wr_data = '{8'h5A, 8'hC3};
        run_cmd("busy_ignore", 1'b0, 7'h50, 2, 1'b0, -1, 1'b1);

        // reset in the middle of the address byte
        wr_data = '{8'hA5, 8'h3C, 8'hFF};
        addr_nack = 0; nack_at = -1;
        clear_model();
        @(negedge clk);
        i_rd_wr = 1'b0; i_slave_addr = 7'h50; i_len = LEN_W'(3); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (16 * 3 + 8) @(negedge clk);
        chk("mid_busy", o_busy, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_reset_no_done", done_cnt, 0);
        chk("mid_reset_idle", o_busy, 0);

        rd_data = '{8'h9E, 8'h01, 8'h77};
        run_cmd("rd3_after_reset", 1'b1, 7'h51, 3, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
